// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx serializer among N_SRC byte sources.
// An internal frame timer paces the bytes, and tx_data is held stable for the whole frame.
module uart_tx_arbiter #(
  parameter int unsigned N_SRC          = 4,
  parameter int unsigned CLK_FEQ        = 50_000_000,
  parameter int unsigned UART_BOT       = 9600,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ready,
  output logic [N_SRC-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic               timeout_err
);

  // One frame is 11 bit times, so uart_tx has finished before the next start pulse.
  localparam int unsigned       FRAME_CYCLES = 11 * (CLK_FEQ / UART_BOT);
  localparam int                PW           = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [19:0]       FRAME_LAST   = 20'(FRAME_CYCLES - 1);
  localparam logic [19:0]       TO_LAST      = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0]     LAST_IDX     = PW'(N_SRC - 1);
  localparam logic [N_SRC-1:0]  ONE          = N_SRC'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t        state;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] rr_ptr;
  logic          last_q;
  logic [19:0]   frame_cnt;
  logic [19:0]   to_cnt;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] next_ptr;
  logic [7:0]    cur_byte;

  // Scan from rr_ptr upward with wrap; iterating downward lets the closest requester win.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % N_SRC);
      if (src_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign next_ptr  = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;
  assign cur_byte  = src_data[{g_idx, 3'b000} +: 8];
  assign src_ready = (state == LOAD) ? grant : '0;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      g_idx       <= '0;
      rr_ptr      <= '0;
      last_q      <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      to_cnt      <= '0;
    end else begin
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant  <= ONE << win_idx;
            g_idx  <= win_idx;
            to_cnt <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (src_valid[g_idx]) begin
            tx_data   <= cur_byte;
            tx_start  <= 1'b1;
            last_q    <= src_last[g_idx];
            frame_cnt <= '0;
            to_cnt    <= '0;
            state     <= SEND;
          end else if (to_cnt == TO_LAST) begin
            // A stalled owner is dropped and moves to lowest priority.
            timeout_err <= 1'b1;
            grant       <= '0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        SEND: begin
          if (frame_cnt == FRAME_LAST) begin
            if (last_q) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state <= LOAD;
            end
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven sources, byte scoreboard,
// a uart_tx line model with a serial decoder, and arbitration vectors plus corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int CLK_FEQ  = 1_000_000;
  localparam int UART_BOT = 100_000;
  localparam int TIMEOUT  = 300;
  localparam int BIT      = CLK_FEQ / UART_BOT;
  localparam int FRAME    = 11 * BIT;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } byte_t;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [7:0]   data;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    int           winner;
  } arb_vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           busy;
  logic           timeout_err;
  logic           ser_line;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int n_rx    = 0;
  int cyc     = 0;
  int last_start_cyc = 0;
  int last_gap = 0;

  byte_t src_q[N][$];
  bit    acc_pend[N];
  exp_t  sb[$];
  logic [7:0] line_exp[$];

  uart_tx_arbiter #(
    .N_SRC         (N),
    .CLK_FEQ       (CLK_FEQ),
    .UART_BOT      (UART_BOT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .grant      (grant),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic byte_t mk(input logic last, input logic [7:0] data);
    byte_t b;
    b.last = last;
    b.data = data;
    return b;
  endfunction

  task automatic wait_grant(input string name);
    int k = 0;
    while (grant == '0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_arrived"}, 32'(grant != '0), 1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle"}, 32'(busy), 0);
  endtask

  task automatic wait_start(input string name);
    int k = 0;
    while (!tx_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_tx_start"}, 32'(tx_start), 1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_grant"}, 32'(grant), 0);
    check({name, "_src_ready"}, 32'(src_ready), 0);
    check({name, "_tx_data"}, 32'(tx_data), 0);
    check({name, "_tx_start"}, 32'(tx_start), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  task automatic drop_others(input int keep);
    for (int i = 0; i < N; i++)
      if (i != keep) src_q[i].delete();
  endtask

  // Source driver: presents the head of each queue; a handshake seen at the negedge
  // is accepted at the next posedge, so the expected byte is pushed right here.
  initial begin
    exp_t e;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc_pend[i]) begin
          if (src_q[i].size() > 0) src_q[i].delete(0);
          acc_pend[i] = 1'b0;
        end
        if (src_q[i].size() > 0) begin
          src_valid[i]       = 1'b1;
          src_data[8*i +: 8] = src_q[i][0].data;
          src_last[i]        = src_q[i][0].last;
        end else begin
          src_valid[i]       = 1'b0;
          src_data[8*i +: 8] = 8'($urandom);
          src_last[i]        = 1'($urandom);
        end
        if (rst && src_valid[i] && src_ready[i]) begin
          acc_pend[i] = 1'b1;
          e.grant = N'(1) << i;
          e.data  = src_data[8*i +: 8];
          sb.push_back(e);
          line_exp.push_back(e.data);
        end
      end
    end
  end

  // Scoreboard monitor on tx_start.
  initial begin
    exp_t e;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_start = 1'b0;
      end else begin
        if (tx_start) begin
          check("tx_start_width", 32'(prev_start), 0);
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: tx_start with no byte expected, tx_data 0x%02h", tx_data);
          end else begin
            e = sb.pop_front();
            check("sb_tx_data", 32'(tx_data), 32'(e.data));
            check("sb_grant", 32'(grant), 32'(e.grant));
          end
          last_gap       = cyc - last_start_cyc;
          last_start_cyc = cyc;
          n_start++;
        end
        prev_start = tx_start;
      end
    end
  end

  // uart_tx line model (start, 8 data LSB first, 2 stop) and an independent mid-bit decoder.
  initial begin
    logic [10:0] sh;
    logic [7:0]  rx;
    int nb, tk, st, cnt;
    nb = 0; tk = 0; st = 0; cnt = 0; sh = '1; rx = '0;
    ser_line = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nb = 0; tk = 0; st = 0; cnt = 0;
        ser_line = 1'b1;
        line_exp.delete();
      end else begin
        if (tx_start) begin
          sh = {2'b11, tx_data, 1'b0};
          nb = 11;
          tk = 0;
        end
        if (nb > 0) begin
          ser_line = sh[0];
          tk++;
          if (tk == BIT) begin
            tk = 0;
            sh = sh >> 1;
            nb--;
          end
        end else begin
          ser_line = 1'b1;
        end
        if (st == 0) begin
          if (ser_line == 1'b0) begin
            st  = 1;
            cnt = 0;
          end
        end else begin
          cnt++;
          if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) rx = {ser_line, rx[7:1]};
          if (cnt == 95) begin
            st = 0;
            check("line_stop_bit", 32'(ser_line), 1);
            if (line_exp.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL line_underflow: decoded 0x%02h with no byte expected", rx);
            end else begin
              check("line_byte", 32'(rx), 32'(line_exp.pop_front()));
            end
            n_rx++;
          end
        end
      end
    end
  end

  initial begin
    repeat (40000) @(negedge clk);
    $display("FAIL watchdog: bench did not finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arb_vec_t vecs[10];
    int k, viol, bad, s0, rx0;

    vecs[0] = '{4'b1111, 0};
    vecs[1] = '{4'b1111, 1};
    vecs[2] = '{4'b1111, 2};
    vecs[3] = '{4'b1111, 3};
    vecs[4] = '{4'b1111, 0};
    vecs[5] = '{4'b0100, 2};
    vecs[6] = '{4'b1010, 3};
    vecs[7] = '{4'b1010, 1};
    vecs[8] = '{4'b1001, 3};
    vecs[9] = '{4'b0011, 0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // T1: two-byte packet from src0, spacing and serial decode.
    rx0 = n_rx;
    src_q[0].push_back(mk(1'b0, 8'h55));
    src_q[0].push_back(mk(1'b1, 8'hA3));
    wait_grant("t1");
    check("t1_grant", 32'(grant), 32'h1);
    wait_idle("t1", 400);
    check("t1_start_gap", 32'(last_gap), FRAME + 1);
    check("t1_grant_released", 32'(grant), 0);
    repeat (5) @(negedge clk);
    check("t1_rx_count", 32'(n_rx - rx0), 2);

    // T2: round-robin vectors starting from rr_ptr=0.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++)
        if (vecs[r].mask[i]) src_q[i].push_back(mk(1'b1, 8'($urandom)));
      wait_grant($sformatf("rr%0d", r));
      check($sformatf("rr%0d_grant", r), 32'(grant), 32'(N'(1) << vecs[r].winner));
      drop_others(vecs[r].winner);
      wait_idle($sformatf("rr%0d", r), 300);
    end

    // T3: lock while src1 sends three bytes and src0 requests.
    s0 = n_start;
    src_q[1].push_back(mk(1'b0, 8'h11));
    src_q[1].push_back(mk(1'b0, 8'h22));
    src_q[1].push_back(mk(1'b1, 8'h33));
    wait_grant("t3");
    check("t3_grant_src1", 32'(grant), 32'h2);
    src_q[0].push_back(mk(1'b1, 8'h44));
    viol = 0;
    k = 0;
    while (grant == 4'b0010 && k < 600) begin
      if (src_ready[0]) viol++;
      @(negedge clk);
      k++;
    end
    check("t3_src0_ready_locked", 32'(viol), 0);
    check("t3_src1_bytes", 32'(n_start - s0), 3);
    check("t3_idle_between", 32'(grant), 0);
    @(negedge clk);
    check("t3_grant_src0", 32'(grant), 32'h1);
    wait_idle("t3", 300);

    // T4: src2 sends one non-last byte then stalls.
    src_q[2].push_back(mk(1'b0, 8'hC7));
    wait_grant("t4");
    check("t4_grant_src2", 32'(grant), 32'h4);
    wait_start("t4");
    k = 0;
    while (!timeout_err && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("t4_timeout_delay", 32'(k), FRAME + TIMEOUT);
    check("t4_busy", 32'(busy), 0);
    check("t4_grant", 32'(grant), 0);
    @(negedge clk);
    check("t4_pulse_width", 32'(timeout_err), 0);
    for (int i = 0; i < N; i++) src_q[i].push_back(mk(1'b1, 8'($urandom)));
    wait_grant("t4_rr");
    check("t4_rr_after_timeout", 32'(grant), 32'h8);
    drop_others(3);
    wait_idle("t4_rr", 300);

    // T5: tx_data held while idle sources toggle src_data every cycle.
    src_q[3].push_back(mk(1'b1, 8'h3C));
    wait_grant("t5");
    wait_start("t5");
    bad = 0;
    for (int j = 0; j < FRAME; j++) begin
      if (tx_data !== 8'h3C) bad++;
      if (j == FRAME - 1) check("t5_busy_last_frame_cycle", 32'(busy), 1);
      @(negedge clk);
    end
    check("t5_tx_data_hold", 32'(bad), 0);
    check("t5_busy_after_frame", 32'(busy), 0);

    // T6: reset mid-SEND with rr_ptr moved away from 0.
    src_q[2].push_back(mk(1'b1, 8'h5A));
    wait_grant("t6_pre");
    wait_idle("t6_pre", 300);
    src_q[1].push_back(mk(1'b1, 8'h81));
    wait_grant("t6");
    check("t6_grant_src1", 32'(grant), 32'h2);
    wait_start("t6");
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero_outputs("t6_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    src_q[0].push_back(mk(1'b1, 8'h0F));
    src_q[3].push_back(mk(1'b1, 8'hF0));
    wait_grant("t6_post");
    check("t6_rr_after_reset", 32'(grant), 32'h1);
    drop_others(0);
    wait_idle("t6_post", 300);

    repeat (20) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    check("line_drained", 32'(line_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
